// File: rtl/clk_div_pkg.sv
// Shared types and constants for the integer clock divider.
//   state_e       : divider control FSM states
//   DIV_WIDTH_DEF : default width of the divide value
package clk_div_pkg;

    localparam int unsigned DIV_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SWITCH = 2'd2
    } state_e;

endpackage

// File: rtl/clk_div_fsm.sv
// Divider control: FSM, period counter, divide-value handshake and the
// posedge toggle flop t0.
//   clk_i, rst_i : clock, async active-high reset
//   en_i         : divided clock enable
//   div_i        : requested divide value, div_valid_i qualifies it
//   t1_i         : current negedge toggle flop value (from top)
//   div_ready_o  : divide value can be accepted
//   t0_o         : posedge toggle flop
//   bypass_o     : active divide value is 0 or 1
//   t1_tog_c_o   : negedge flop must toggle at the coming negedge
module clk_div_fsm
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_WIDTH   = DIV_WIDTH_DEF,
    parameter int unsigned DEFAULT_DIV = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 div_valid_i,
    input  logic                 t1_i,
    output logic                 div_ready_o,
    output logic                 t0_o,
    output logic                 bypass_o,
    output logic                 t1_tog_c_o
);

    localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] TWO     = DIV_WIDTH'(2);

    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] pend_q, pend_d;
    logic                 t0_q, t0_d;
    logic                 ready_q, ready_d;
    logic                 bypass_q, bypass_d;

    logic                 accept;
    logic                 at_end;
    logic [DIV_WIDTH-1:0] cnt_inc;
    logic                 run_tog;

    assign accept  = div_valid_i & ready_q;
    // Period boundary; in bypass every cycle is a boundary.
    assign at_end  = bypass_q | (cnt_q == div_q - ONE);
    assign cnt_inc = at_end ? '0 : cnt_q + ONE;
    // t0 toggles entering phase 0, and entering phase N/2 for even N.
    assign run_tog = ~bypass_q &
                     ((cnt_inc == '0) | (~div_q[0] & (cnt_inc == (div_q >> 1))));

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            div_q    <= DIV_RST;
            pend_q   <= DIV_RST;
            t0_q     <= 1'b0;
            ready_q  <= 1'b1;
            bypass_q <= (DIV_RST < TWO);
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            pend_q   <= pend_d;
            t0_q     <= t0_d;
            ready_q  <= ready_d;
            bypass_q <= bypass_d;
        end
    end

    // Next-state logic. Whenever the divided clock is parked, t0 is made
    // equal to t1 so the XOR stays low; t1 is a negedge flop and cannot be
    // cleared on the same edge as t0 without a glitch. Starting a period
    // sets t0 = ~t1 so the output rises on that posedge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        pend_d  = pend_q;
        t0_d    = t0_q;
        if (accept) begin
            pend_d = div_i;
        end
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                t0_d  = t1_i;
                if (accept) begin
                    div_d = div_i;
                end else if (en_i) begin
                    state_d = ST_RUN;
                    t0_d    = t1_i ^ ~bypass_q;
                end
            end
            ST_RUN: begin
                if (at_end && !en_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    t0_d    = t1_i;
                    if (accept) begin
                        div_d = div_i;
                    end
                end else begin
                    if (accept) begin
                        state_d = ST_SWITCH;
                    end
                    cnt_d = cnt_inc;
                    t0_d  = t0_q ^ run_tog;
                end
            end
            ST_SWITCH: begin
                if (at_end) begin
                    div_d = pend_q;
                    cnt_d = '0;
                    if (en_i) begin
                        state_d = ST_RUN;
                        t0_d    = t1_i ^ (pend_q >= TWO);
                    end else begin
                        state_d = ST_IDLE;
                        t0_d    = t1_i;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    t0_d  = t0_q ^ run_tog;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        ready_d  = (state_d != ST_SWITCH);
        bypass_d = (div_d < TWO);
    end

    // t1 toggles mid-cycle at phase (N-1)/2, odd N only, while counting.
    assign t1_tog_c_o = (state_q != ST_IDLE) & ~bypass_q & div_q[0] &
                        (cnt_q == ((div_q - ONE) >> 1));

    assign div_ready_o = ready_q;
    assign t0_o        = t0_q;
    assign bypass_o    = bypass_q;

endmodule

// File: rtl/tc_clk_mux2.sv
// Clock-path 2:1 mux cell.
//   clk0_i : selected when sel_i = 0
//   clk1_i : selected when sel_i = 1
//   sel_i  : select
//   clk_o  : muxed clock
module tc_clk_mux2 (
    input  logic clk0_i,
    input  logic clk1_i,
    input  logic sel_i,
    output logic clk_o
);

    assign clk_o = sel_i ? clk1_i : clk0_i;

endmodule

// File: rtl/tc_clk_xor2.sv
// Clock-path XOR cell combining the two toggle flops.
//   clk0_i, clk1_i : clock inputs
//   clk_o          : clk0_i ^ clk1_i
module tc_clk_xor2 (
    input  logic clk0_i,
    input  logic clk1_i,
    output logic clk_o
);

    assign clk_o = clk0_i ^ clk1_i;

endmodule

// File: rtl/clk_int_div.sv
// Integer clock divider with 50% duty for any N, glitch-free run-time
// divide changes and a test-mode bypass.
//   clk_i, rst_i : source clock, async active-high reset
//   en_i         : divided clock enable (stops low at a period boundary)
//   test_mode_i  : clk_o = clk_i
//   div_i        : divide value N (0/1 = bypass), div_valid_i qualifies it
//   div_ready_o  : div_i accepted this cycle when valid
//   clk_o        : divided clock
module clk_int_div
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_WIDTH   = DIV_WIDTH_DEF,
    parameter int unsigned DEFAULT_DIV = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 test_mode_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 div_valid_i,
    output logic                 div_ready_o,
    output logic                 clk_o
);

    logic t0;
    logic t1_q, t1_d;
    logic t1_tog_c;
    logic bypass;
    logic div_clk;
    logic mux_sel;

    clk_div_fsm #(
        .DIV_WIDTH   (DIV_WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_fsm (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .div_i       (div_i),
        .div_valid_i (div_valid_i),
        .t1_i        (t1_q),
        .div_ready_o (div_ready_o),
        .t0_o        (t0),
        .bypass_o    (bypass),
        .t1_tog_c_o  (t1_tog_c)
    );

    // Negedge toggle flop supplying the half-cycle edge for odd N
    assign t1_d = t1_q ^ t1_tog_c;

    always_ff @(negedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            t1_q <= 1'b0;
        end else begin
            t1_q <= t1_d;
        end
    end

    assign mux_sel = bypass | test_mode_i;

    tc_clk_xor2 u_clk_xor (
        .clk0_i (t0),
        .clk1_i (t1_q),
        .clk_o  (div_clk)
    );

    tc_clk_mux2 u_clk_mux (
        .clk0_i (div_clk),
        .clk1_i (clk_i),
        .sel_i  (mux_sel),
        .clk_o  (clk_o)
    );

endmodule

// File: tb/tb_clk_int_div.sv
// Directed bench for clk_int_div. clk_o is sampled once per half cycle
// (1 ns after each clk_i edge) and collected as a '0'/'1' string.
module tb_clk_int_div;

    localparam int unsigned DW = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          en_i;
    logic          test_mode_i;
    logic [DW-1:0] div_i;
    logic          div_valid_i;
    logic          div_ready_o;
    logic          clk_o;

    int    n_tests = 0;
    int    n_fail  = 0;
    string obs;
    string exp_s;

    clk_int_div #(
        .DIV_WIDTH   (DW),
        .DEFAULT_DIV (1)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .test_mode_i (test_mode_i),
        .div_i       (div_i),
        .div_valid_i (div_valid_i),
        .div_ready_o (div_ready_o),
        .clk_o       (clk_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000 ns, expected finish");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; records both halves of n cycles, returns at posedge+1.
    task automatic sample_cycles(input int n);
        string b;
        for (int i = 0; i < n; i++) begin
            b   = (clk_o === 1'b1) ? "1" : "0";
            obs = {obs, b};
            @(negedge clk_i); #1;
            b   = (clk_o === 1'b1) ? "1" : "0";
            obs = {obs, b};
            @(posedge clk_i); #1;
        end
    endtask

    task automatic go_idle();
        en_i = 1'b0;
        repeat (12) @(posedge clk_i);
        #1;
    endtask

    task automatic do_load(input logic [DW-1:0] n, input string name);
        bit done;
        done        = 1'b0;
        div_i       = n;
        div_valid_i = 1'b1;
        for (int i = 0; i < 8 && !done; i++) begin
            if (div_ready_o === 1'b1) done = 1'b1;
            @(posedge clk_i); #1;
        end
        div_valid_i = 1'b0;
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s: div_ready_o stayed %b for 8 cycles, expected 1", name, div_ready_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; en_i = 1'b1; test_mode_i = 1'b0;
        div_i = '0; div_valid_i = 1'b0;
        @(posedge clk_i); #1;
        n_tests++;
        if (div_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 1", div_ready_o);
        end
        n_tests++;
        if (clk_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_clk_hi: got %b expected 1", clk_o);
        end
        @(negedge clk_i); #1;
        n_tests++;
        if (clk_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_clk_lo: got %b expected 0", clk_o);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        obs = "";
        sample_cycles(4);
        exp_s = "10101010";
        n_tests++;
        if (obs != exp_s) begin
            n_fail++; $display("FAIL bypass_pattern: got %s expected %s", obs, exp_s);
        end
        n_tests++;
        if (div_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL bypass_ready: got %b expected 1", div_ready_o);
        end
    endtask

    task automatic test_div(input logic [DW-1:0] n, input string expect_pat, input string name);
        go_idle();
        do_load(n, name);
        en_i = 1'b1;
        obs  = "";
        sample_cycles(1 + 2 * int'(n));
        n_tests++;
        if (obs != expect_pat) begin
            n_fail++; $display("FAIL %s: got %s expected %s", name, obs, expect_pat);
        end
    endtask

    task automatic test_switch();
        go_idle();
        do_load(8'd4, "switch_load4");
        en_i = 1'b1;
        obs  = "";
        sample_cycles(2);
        div_i = 8'd7; div_valid_i = 1'b1;
        sample_cycles(1);
        n_tests++;
        if (div_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL switch_ready_cnt2: got %b expected 0", div_ready_o);
        end
        div_i = 8'd2; div_valid_i = 1'b1;
        sample_cycles(1);
        n_tests++;
        if (div_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL switch_ready_cnt3: got %b expected 0", div_ready_o);
        end
        div_valid_i = 1'b0;
        sample_cycles(1);
        n_tests++;
        if (div_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL switch_ready_after: got %b expected 1", div_ready_o);
        end
        sample_cycles(14);
        exp_s = {"00", "11110000", "11111110000000", "11111110000000"};
        n_tests++;
        if (obs != exp_s) begin
            n_fail++; $display("FAIL switch_pattern: got %s expected %s", obs, exp_s);
        end
    endtask

    task automatic test_en_drop();
        go_idle();
        do_load(8'd6, "endrop_load6");
        en_i = 1'b1;
        obs  = "";
        sample_cycles(2);
        en_i = 1'b0;
        sample_cycles(8);
        en_i = 1'b1;
        sample_cycles(7);
        exp_s = {"00", "11", "1111000000", "000000", "00", "111111000000"};
        n_tests++;
        if (obs != exp_s) begin
            n_fail++; $display("FAIL en_drop_pattern: got %s expected %s", obs, exp_s);
        end
    endtask

    task automatic test_test_mode();
        test_mode_i = 1'b1;
        obs = "";
        sample_cycles(2);
        n_tests++;
        if (div_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL test_mode_ready: got %b expected 1", div_ready_o);
        end
        test_mode_i = 1'b0;
        sample_cycles(5);
        exp_s = {"1010", "1100000011"};
        n_tests++;
        if (obs != exp_s) begin
            n_fail++; $display("FAIL test_mode_pattern: got %s expected %s", obs, exp_s);
        end
    endtask

    task automatic test_reset_in_switch();
        div_i = 8'd4; div_valid_i = 1'b1;
        sample_cycles(1);
        div_valid_i = 1'b0;
        n_tests++;
        if (div_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_sw_ready_before: got %b expected 0", div_ready_o);
        end
        #2;
        rst_i = 1'b1;
        #1;
        n_tests++;
        if (div_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL rst_sw_ready_async: got %b expected 1", div_ready_o);
        end
        @(negedge clk_i); #1;
        n_tests++;
        if (clk_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_sw_clk_lo: got %b expected 0", clk_o);
        end
        @(posedge clk_i); #1;
        n_tests++;
        if (clk_o !== 1'b1) begin
            n_fail++; $display("FAIL rst_sw_clk_hi: got %b expected 1", clk_o);
        end
        rst_i = 1'b0;
        obs = "";
        sample_cycles(6);
        exp_s = "101010101010";
        n_tests++;
        if (obs != exp_s) begin
            n_fail++; $display("FAIL rst_sw_pattern: got %s expected %s", obs, exp_s);
        end
    endtask

    initial begin
        test_reset();
        test_div(8'd4, {"00", "11110000", "11110000"}, "div4_pattern");
        test_div(8'd3, {"00", "111000", "111000"}, "div3_pattern");
        test_div(8'd5, {"00", "1111100000", "1111100000"}, "div5_pattern");
        test_switch();
        test_en_drop();
        test_test_mode();
        test_reset_in_switch();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_int_div.md
CLK_INT_DIV -- requirements
Module: clk_int_div

Interface
REQ-001 Parameter DIV_WIDTH, default 8: width of the divide value.
REQ-002 Parameter DEFAULT_DIV, default 1: divide value loaded at reset.
REQ-003 clk_i  input  1  source clock; the single clock of the block; positive and negative edges used.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 en_i  input  1  divided clock enable; low stops clk_o low at a period boundary.
REQ-006 test_mode_i  input  1  forces clk_o = clk_i (bypass), combinational, no handshake.
REQ-007 div_i  input  DIV_WIDTH  requested divide value N.
REQ-008 div_valid_i  input  1  div_i is valid.
REQ-009 div_ready_o  output  1  block accepts div_i this cycle.
REQ-010 clk_o  output  1  divided clock, 50% duty for all N.

Function
REQ-011 N = 0 or 1 SHALL mean bypass: clk_o = clk_i.
REQ-012 N >= 2 SHALL give clk_o period N x clk_i period, high time N/2 clk_i periods (exact, including odd N).
REQ-013 Core: counter cnt, 0..N-1, wraps to 0 at N-1, increments on clk_i posedge in RUN.
REQ-014 Posedge toggle flop t0 SHALL toggle when cnt == 0; for even N, also when cnt == N/2.
REQ-015 Negedge toggle flop t1 SHALL toggle when cnt == (N-1)/2, odd N only; held for even N.
REQ-016 Divided clock = t0 XOR t1; final output = mux(sel = bypass or test_mode_i, divided, clk_i).
REQ-017 FSM states: IDLE, RUN, SWITCH.
REQ-018 IDLE: cnt = 0, t0 = t1 = 0, clk_o low (unless bypass); en_i high -> RUN next posedge, first clk_o rise on that posedge (N >= 2).
REQ-019 RUN: en_i low -> IDLE at the posedge where cnt == N-1 (end of low half); no truncated high pulse.
REQ-020 div_ready_o SHALL be 1 in IDLE and RUN, 0 in SWITCH.
REQ-021 Accept = div_valid_i & div_ready_o; accepted value is stored in a pending register in that cycle.
REQ-022 Accept in IDLE: pending value loaded into active N on the same posedge; stay IDLE.
REQ-023 Accept in RUN: -> SWITCH; current N keeps running until cnt == N-1, then on that posedge load pending N, cnt = 0, t0 = t1 = 0, -> RUN.
REQ-024 Accept in RUN while active N is bypass: load on the next posedge, -> RUN (no SWITCH dwell beyond one cycle).
REQ-025 en_i falling while in SWITCH: load pending N at the boundary, go to IDLE.
REQ-026 div_valid_i while in SWITCH SHALL be ignored (not stored); requester holds valid until ready.
REQ-027 clk_o SHALL never produce a high or low phase shorter than min(old, new) half period around any switch.
REQ-028 test_mode_i SHALL not alter FSM, counter, or handshake.

Reset
REQ-029 rst_i asserted: state = IDLE, active N = pending = DEFAULT_DIV, cnt = 0, t0 = t1 = 0, immediately (asynchronous).
REQ-030 Reset values: div_ready_o = 1; clk_o = 0 if DEFAULT_DIV >= 2, else clk_i.
REQ-031 Reset mid-period or mid-SWITCH SHALL discard pending value; no output glitch beyond the truncated current phase.

Structure
REQ-032 Shared package clk_div_pkg holds the FSM state enum and DIV_WIDTH default constant.
REQ-033 Final select SHALL instantiate tc_clk_mux2; the t0/t1 combine SHALL instantiate tc_clk_xor2; no other logic on the clock path.
REQ-034 One sub-module: clk_div_fsm (state, counter, handshake, t0); t1 negedge flop and clock cells stay at top.

Verification
REQ-035 Reset with DEFAULT_DIV 1, en_i 1 -> clk_o follows clk_i; div_ready_o 1.
REQ-036 Load N=4 in IDLE, en_i 1 -> clk_o period 4 clk_i, high 2, low 2; first rise on RUN entry posedge.
REQ-037 Load N=3 -> clk_o period 3, high 1.5 clk_i periods; repeat for N=5 (high 2.5).
REQ-038 Running N=4, request N=7 at cnt=1 -> ready low until cnt=3 posedge, then N=7 with no short pulse; second request during SWITCH ignored.
REQ-039 Running N=6, drop en_i at cnt=1 -> clk_o completes high and low halves, held low from cnt wrap; re-raise -> restarts cleanly.
REQ-040 Assert rst_i mid-SWITCH and toggle test_mode_i during RUN -> state IDLE, pending lost; test_mode_i gives clk_o = clk_i with counter unaffected.
